// File: rtl/uart_avmm_bridge.sv
// UART-frame to Avalon-MM master bridge.
// Each received frame becomes one read or write on the Avalon bus. Read data
// (or an error word on a stalled-out read) goes back as one transmit word.
// A one-deep pending slot absorbs a frame that arrives while a command is
// still in flight; anything beyond that is dropped and flagged.
module uart_avmm_bridge #(
    parameter int          ADDR_SIZE = 4,
    parameter int          VAL_SIZE  = 4,
    parameter int          TIMEOUT   = 1024,
    parameter logic [31:0] ERR_WORD  = 32'hdeadbeef
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              rx_valid,
    input  logic [8*(ADDR_SIZE+VAL_SIZE)-1:0] rx_data,
    input  logic                              tx_ready,
    output logic                              tx_valid,
    output logic [8*VAL_SIZE-1:0]             tx_data,
    output logic [8*ADDR_SIZE-1:0]            m_address,
    output logic                              m_read,
    output logic                              m_write,
    output logic [8*VAL_SIZE-1:0]             m_writedata,
    input  logic [8*VAL_SIZE-1:0]             m_readdata,
    input  logic                              m_waitrequest,
    output logic                              overflow,
    output logic                              timeout
);

    localparam int FW = 8 * (ADDR_SIZE + VAL_SIZE);
    localparam int AW = 8 * ADDR_SIZE;
    localparam int DW = 8 * VAL_SIZE;
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic           TO_EN   = (TIMEOUT != 0);
    localparam logic [CW-1:0]  TO_LAST = (TIMEOUT == 0) ? {CW{1'b0}} : CW'(TIMEOUT - 1);
    localparam logic [DW-1:0]  ERR_VAL = DW'(ERR_WORD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           pend_vld_q, pend_vld_d;
    logic [FW-1:0]  pend_q, pend_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [DW-1:0]  txd_q, txd_d;
    logic           rd_q, rd_d;
    logic           wr_q, wr_d;
    logic           txv_q, txv_d;
    logic           ovf_q, ovf_d;
    logic           tmo_q, tmo_d;

    logic [FW-1:0]  cmd_s;
    logic           start_s;
    logic           done_s;
    logic           abort_s;

    // Decode which command launches and whether the bus cycle ends this clock.
    always_comb begin
        start_s = (state_q == ST_IDLE) && (rx_valid || pend_vld_q);
        cmd_s   = pend_vld_q ? pend_q : rx_data;
        done_s  = (state_q == ST_BUS) && !m_waitrequest;
        abort_s = (state_q == ST_BUS) && m_waitrequest && TO_EN && (cnt_q == TO_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: launch, complete/abort, then hand off the response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) state_d = ST_BUS;
                else         state_d = ST_IDLE;
            end
            ST_BUS: begin
                if (done_s || abort_s) state_d = rd_q ? ST_RESP : ST_IDLE;
                else                   state_d = ST_BUS;
            end
            ST_RESP: begin
                if (tx_ready) state_d = ST_IDLE;
                else          state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values: pending slot, bus strobes, response.
    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        txd_d      = txd_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        txv_d      = 1'b0;
        ovf_d      = ovf_q;
        tmo_d      = tmo_q;

        // A pending frame launching from IDLE frees its slot in the same
        // cycle, so a simultaneous new frame can take that slot.
        if (rx_valid) begin
            if (state_q == ST_IDLE) begin
                if (pend_vld_q) pend_d = rx_data;
                else            pend_d = pend_q;
            end else if (!pend_vld_q) begin
                pend_vld_d = 1'b1;
                pend_d     = rx_data;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (start_s) begin
            pend_vld_d = 1'b0;
        end else begin
            pend_vld_d = pend_vld_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    addr_d  = {1'b0, cmd_s[FW-2:DW]};
                    wdata_d = cmd_s[DW-1:0];
                    wr_d    = cmd_s[FW-1];
                    rd_d    = !cmd_s[FW-1];
                    cnt_d   = {CW{1'b0}};
                end else begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                end
            end
            ST_BUS: begin
                if (done_s) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (rd_q) txd_d = m_readdata;
                    else      txd_d = txd_q;
                end else if (abort_s) begin
                    rd_d  = 1'b0;
                    wr_d  = 1'b0;
                    tmo_d = 1'b1;
                    if (rd_q) txd_d = ERR_VAL;
                    else      txd_d = txd_q;
                end else begin
                    cnt_d = cnt_q + CW'(1'b1);
                end
            end
            ST_RESP: begin
                if (tx_ready) txv_d = 1'b1;
                else          txv_d = 1'b0;
            end
            default: begin
                rd_d = 1'b0;
                wr_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset drops the strobes immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_vld_q <= 1'b0;
            pend_q     <= {FW{1'b0}};
            cnt_q      <= {CW{1'b0}};
            addr_q     <= {AW{1'b0}};
            wdata_q    <= {DW{1'b0}};
            txd_q      <= {DW{1'b0}};
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            txv_q      <= 1'b0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            txd_q      <= txd_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            txv_q      <= txv_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
        end
    end

    assign tx_valid    = txv_q;
    assign tx_data     = txd_q;
    assign m_address   = addr_q;
    assign m_read      = rd_q;
    assign m_write     = wr_q;
    assign m_writedata = wdata_q;
    assign overflow    = ovf_q;
    assign timeout     = tmo_q;

endmodule

// File: tb/tb_uart_avmm_bridge.sv
// Bench for uart_avmm_bridge: directed scenarios followed by randomized
// single commands against a bench-side memory model.
module tb_uart_avmm_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx_valid;
    logic [63:0] rx_data;
    logic        tx_ready;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        m_waitrequest;
    logic        overflow;
    logic        timeout;

    int n_chk  = 0;
    int n_fail = 0;

    // Observed bus completions {write, address, writedata} and response words.
    logic [64:0] bus_q[$];
    logic [31:0] tx_q[$];
    int          strobe_cycles = 0;

    logic [31:0] mem_model [8];
    logic [31:0] smem [8];

    always #5 clk = ~clk;

    uart_avmm_bridge #(
        .ADDR_SIZE(4),
        .VAL_SIZE (4),
        .TIMEOUT  (8),
        .ERR_WORD (32'hdeadbeef)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .tx_ready     (tx_ready),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .m_address    (m_address),
        .m_read       (m_read),
        .m_write      (m_write),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .m_waitrequest(m_waitrequest),
        .overflow     (overflow),
        .timeout      (timeout)
    );

    function automatic logic [63:0] mk(input logic wr, input logic [30:0] addr, input logic [31:0] data);
        return {wr, addr, data};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, logging what the bus and response ports did.
    task automatic tick();
        if ((m_read || m_write) && !m_waitrequest) bus_q.push_back({m_write, m_address, m_writedata});
        if (m_read || m_write) strobe_cycles++;
        @(posedge clk);
        #1;
        if (tx_valid) tx_q.push_back(tx_data);
    endtask

    // Slave that stalls each transfer for a fixed number of cycles.
    task automatic serve(input int n, input int stall);
        int cur = 0;
        for (int c = 0; c < n; c++) begin
            if (m_read || m_write) begin
                if (cur < stall) begin
                    m_waitrequest = 1'b1;
                    cur++;
                end else begin
                    m_waitrequest = 1'b0;
                    cur = 0;
                end
            end else begin
                m_waitrequest = 1'b1;
                cur = 0;
            end
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sc;
        int          nb;
        int          nt;
        int          stall;
        int          cur;
        logic        wr;
        logic [30:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        done;
        logic [64:0] rec;

        reset_n = 1'b0; rx_valid = 1'b0; rx_data = 64'd0; tx_ready = 1'b0;
        m_readdata = 32'd0; m_waitrequest = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem_model[i] = 32'd0;
            smem[i]      = 32'd0;
        end
        #12;
        chk("rst_tx_valid0", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_m_addr", m_address, 0);
        chk("rst_m_read", m_read, 0);
        chk("rst_m_write", m_write, 0);
        chk("rst_m_wdata", m_writedata, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_timeout", timeout, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick();
        chk("idle_no_strobe", {m_read, m_write}, 0);

        // Zero-wait read
        tx_ready = 1'b1; m_waitrequest = 1'b0; m_readdata = 32'h12345678;
        rx_valid = 1'b1; rx_data = mk(1'b0, 31'd3, 32'd0);
        tick();
        rx_valid = 1'b0;
        chk("t1_read", m_read, 1);
        chk("t1_write", m_write, 0);
        chk("t1_addr", m_address, 3);
        tick();
        chk("t1_read_drop", m_read, 0);
        chk("t1_txv_early", tx_valid, 0);
        tick();
        chk("t1_txv", tx_valid, 1);
        chk("t1_txd", tx_data, 32'h12345678);
        tick();
        chk("t1_txv_pulse", tx_valid, 0);

        // Stalled write: four stall cycles, five strobe cycles
        bus_q.delete(); tx_q.delete(); sc = strobe_cycles;
        m_waitrequest = 1'b1;
        rx_valid = 1'b1; rx_data = mk(1'b1, 31'd5, 32'hA5A5A5A5);
        tick();
        rx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_wr_stable", {m_write, m_read, m_address, m_writedata}, {2'b10, 32'd5, 32'hA5A5A5A5});
            m_waitrequest = (i < 4);
            tick();
        end
        chk("t2_wr_drop", m_write, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("t2_strobe_cycles", strobe_cycles - sc, 5);
        chk("t2_bus_count", bus_q.size(), 1);
        chk("t2_no_tx", tx_q.size(), 0);

        // Pending and overflow: three frames on consecutive stalled cycles
        bus_q.delete(); tx_q.delete();
        m_waitrequest = 1'b1;
        rx_valid = 1'b1; rx_data = mk(1'b1, 31'd1, 32'h11);
        tick();
        rx_data = mk(1'b1, 31'd2, 32'h22);
        tick();
        rx_data = mk(1'b1, 31'd3, 32'h33);
        tick();
        rx_valid = 1'b0;
        chk("t3_overflow", overflow, 1);
        serve(25, 3);
        chk("t3_bus_count", bus_q.size(), 2);
        if (bus_q.size() == 2) begin
            chk("t3_first", bus_q[0], {1'b1, 32'd1, 32'h11});
            chk("t3_second", bus_q[1], {1'b1, 32'd2, 32'h22});
        end
        chk("t3_overflow_sticky", overflow, 1);
        chk("t3_no_timeout", timeout, 0);

        // Timeout on a read stuck in waitrequest
        bus_q.delete(); tx_q.delete(); sc = strobe_cycles;
        m_waitrequest = 1'b1; tx_ready = 1'b1;
        rx_valid = 1'b1; rx_data = mk(1'b0, 31'd7, 32'd0);
        tick();
        rx_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("t4_strobe_cycles", strobe_cycles - sc, 8);
        chk("t4_timeout", timeout, 1);
        chk("t4_no_completion", bus_q.size(), 0);
        chk("t4_tx_count", tx_q.size(), 1);
        chk("t4_txd", tx_data, 32'hDEADBEEF);

        // Backpressure on the response
        tx_q.delete();
        tx_ready = 1'b0; m_waitrequest = 1'b0; m_readdata = 32'hCAFEF00D;
        rx_valid = 1'b1; rx_data = mk(1'b0, 31'd9, 32'd0);
        tick();
        rx_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("t5_held", tx_q.size(), 0);
        tx_ready = 1'b1;
        tick();
        chk("t5_txv", tx_valid, 1);
        chk("t5_txd", tx_data, 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) tick();
        chk("t5_once", tx_q.size(), 1);

        // Asynchronous reset mid-transaction with a pending frame
        m_waitrequest = 1'b1;
        rx_valid = 1'b1; rx_data = mk(1'b1, 31'd4, 32'h44);
        tick();
        rx_data = mk(1'b0, 31'd5, 32'd0);
        tick();
        rx_valid = 1'b0;
        chk("t6_busy", m_write, 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_async_strobe", {m_read, m_write}, 0);
        chk("t6_flags_clear", {overflow, timeout, tx_valid}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus_q.delete(); tx_q.delete(); sc = strobe_cycles;
        m_waitrequest = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        chk("t6_no_strobe", strobe_cycles - sc, 0);
        chk("t6_no_tx", tx_q.size(), 0);
        m_readdata = 32'h0BADF00D;
        rx_valid = 1'b1; rx_data = mk(1'b0, 31'd6, 32'd0);
        tick();
        rx_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("t6_new_tx", tx_q.size(), 1);
        if (tx_q.size() == 1) chk("t6_new_txd", tx_q[0], 32'h0BADF00D);

        // Randomized commands against the memory model
        bus_q.delete(); tx_q.delete();
        for (int k = 0; k < 24; k++) begin
            wr     = 1'($urandom_range(0, 1));
            addr   = 31'($urandom);
            data   = $urandom;
            stall  = $urandom_range(0, 5);
            exp_rd = mem_model[addr[2:0]];
            nb = bus_q.size(); nt = tx_q.size(); sc = strobe_cycles;
            m_waitrequest = 1'b1;
            tx_ready = 1'($urandom_range(0, 1));
            rx_valid = 1'b1; rx_data = mk(wr, addr, data);
            tick();
            rx_valid = 1'b0;
            cur = 0; done = 1'b0;
            for (int c = 0; c < 80 && !done; c++) begin
                if (m_read || m_write) begin
                    if (cur < stall) begin
                        m_waitrequest = 1'b1;
                        cur++;
                    end else begin
                        m_waitrequest = 1'b0;
                    end
                    m_readdata = smem[m_address[2:0]];
                    if (m_write && !m_waitrequest) smem[m_address[2:0]] = m_writedata;
                end else begin
                    m_waitrequest = 1'b1;
                end
                tx_ready = 1'($urandom_range(0, 1));
                tick();
                done = wr ? ((bus_q.size() > nb) && !(m_read || m_write)) : (tx_q.size() > nt);
            end
            chk("rnd_done", done, 1);
            if (wr) mem_model[addr[2:0]] = data;
            chk("rnd_strobe_cycles", strobe_cycles - sc, stall + 1);
            if (bus_q.size() > nb) begin
                rec = bus_q[nb];
                chk("rnd_op", rec[64], wr);
                chk("rnd_addr", rec[63:32], {1'b0, addr});
                if (wr) chk("rnd_wdata", rec[31:0], data);
            end
            if (!wr && tx_q.size() > nt) chk("rnd_rdata", tx_q[nt], exp_rd);
        end
        chk("rnd_no_overflow", overflow, 0);
        chk("rnd_no_timeout", timeout, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_avmm_bridge.md
Name: uart_avmm_bridge

Overview:
- Sits between the framed UART receiver/transmitter and the program-logic Avalon-MM slave.
- Decodes each received frame as a read or write command and drives a compliant Avalon-MM master transaction, honouring waitrequest.
- Returns read data as a transmit frame.
- Provides a one-deep pending-command buffer, a waitrequest timeout and a sticky overflow flag, so a slow slave never loses or corrupts host commands silently.

Parameters:
- ADDR_SIZE, 4, address field width in bytes; the frame MSB is the opcode.
- VAL_SIZE, 4, data field width in bytes.
- TIMEOUT, 1024, maximum cycles a transaction may stall on waitrequest before it is aborted; 0 disables the timeout.
- ERR_WORD, 32'hdeadbeef, read response returned on timeout; truncated or zero-extended to 8*VAL_SIZE.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle pulse: a complete command frame is on rx_data.
- rx_data  in  8*(ADDR_SIZE+VAL_SIZE)  frame; MSB=1 write, MSB=0 read; next bits are the address; low 8*VAL_SIZE bits are write data.
- tx_ready  in  1  UART transmitter can accept a word.
- tx_valid  out  1  one-cycle pulse: tx_data is a response word.
- tx_data  out  8*VAL_SIZE  response word.
- m_address  out  8*ADDR_SIZE  {1'b0, frame address bits}.
- m_read  out  1  Avalon read strobe.
- m_write  out  1  Avalon write strobe.
- m_writedata  out  8*VAL_SIZE  write data.
- m_readdata  in  8*VAL_SIZE  read data; valid in the cycle m_read is high and m_waitrequest is low.
- m_waitrequest  in  1  slave stall.
- overflow  out  1  sticky: a frame was dropped.
- timeout  out  1  sticky: a transaction was aborted.

Behaviour:
- Reset (async assert, sync release): state=IDLE, pending buffer empty, timeout counter=0. All outputs are 0: tx_valid, tx_data, m_*, overflow, timeout.
- Command capture: when rx_valid=1, the frame is latched into the current-command register if state=IDLE. Otherwise it goes into the pending register if that register is empty. Otherwise the frame is dropped and overflow is set to 1.
- State IDLE:
  - If a frame arrives or pending is full, go to BUS next cycle with m_address, m_writedata, m_read/m_write registered from the command.
  - Pending takes priority over a new rx frame. In that case the new frame enters pending in the same cycle, so nothing is lost.
- State BUS:
  - Exactly one of m_read or m_write is high. Address, data and strobe stay stable while m_waitrequest=1.
  - When m_waitrequest=0 the transaction completes that cycle and the strobe drops next cycle. Minimum bus occupancy is 1 cycle.
  - Read completion: capture m_readdata into tx_data and go to RESP.
  - Write completion: go to IDLE. Writes produce no response frame.
  - The counter increments each stalled cycle. When TIMEOUT!=0 and the counter reaches TIMEOUT:
    - drop the strobe and set timeout=1;
    - a read loads ERR_WORD into tx_data and goes to RESP;
    - a write goes to IDLE.
  - The counter clears on entry to BUS.
- State RESP:
  - Wait for tx_ready=1, then assert tx_valid for exactly 1 cycle and go to IDLE.
  - tx_data holds its value until the next read completes.
- Latency: rx_valid at cycle N in IDLE gives a strobe at N+1. A zero-wait read gives tx_valid at N+3 when tx_ready is high.
- Back-to-back: a frame arriving in the same cycle the FSM returns to IDLE is accepted; there is no dead cycle beyond the IDLE cycle itself.
- overflow and timeout clear only on reset.
- Reset mid-transaction:
  - strobes drop asynchronously;
  - the in-flight command and the pending command are discarded;
  - no tx_valid is emitted after release until a new read completes.

Test Plan:
- Zero-wait read: rx frame {0, addr=3} with m_waitrequest=0, m_readdata=0x12345678 -> m_read high 1 cycle with m_address=3; tx_valid pulse 2 cycles later with tx_data=0x12345678.
- Stalled write: frame MSB=1, addr=5, data=0xA5A5A5A5, m_waitrequest high 4 cycles -> m_write, address and data stable for 5 cycles; no tx_valid.
- Pending/overflow: 3 frames arrive on consecutive cycles while the slave stalls -> first executes, second executes next, third dropped with overflow=1; exactly 2 bus transactions observed.
- Timeout: TIMEOUT=8, read with waitrequest stuck at 1 -> strobe drops after 8 stall cycles; timeout=1; tx_data=0xDEADBEEF.
- Backpressure: read completes while tx_ready=0 for 10 cycles -> tx_valid fires on the first cycle tx_ready=1, exactly once.
- Async reset: reset_n pulled low mid-BUS with a pending frame -> m_read/m_write are 0 immediately; after release no transaction or tx_valid occurs until a new rx_valid.
